i2c_target_regfile: RTL and testbench

I2C target (responder) that answers a bus initiator such as the team's EEPROM-style master, on open-drain SCL/SDA lines. It holds a small byte-wide register file behind a 7-bit device address. It supports pointer-then-data writes and sequential reads with pointer auto-increment. It sits on the bus side opposite the master, oversamples the bus with the system clock, and exposes a side read port plus write strobes for local logic.

---
 rtl/i2c_target_pkg.sv | 9 +
 rtl/i2c_bus_sync.sv | 36 +++
 rtl/i2c_target_regfile.sv | 147 ++++++++++++++
 tb/tb_i2c_target_regfile.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_target_pkg.sv
// i2c_target_pkg: states and constants shared by the I2C register-file target
package i2c_target_pkg;
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
  } i2c_tgt_state_e;
  localparam logic ACK = 1'b0;
  localparam logic NACK = 1'b1;
  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h50;
endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: synchronises SCL/SDA and flags SCL edges plus START/STOP conditions
module i2c_bus_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);
  logic [2:0] scl_q, scl_d, sda_q, sda_d;
  logic arm_q, arm_d;
  logic scl_s, scl_p, sda_p;
  // the chains keep tracking the pins through reset so releasing it never fakes an edge
  always_comb begin
    scl_d = {scl_q[1:0], scl_in};
    sda_d = {sda_q[1:0], sda_in};
    arm_d = 1'b1;
  end
  always_ff @(posedge clk) begin
    scl_q <= scl_d;
    sda_q <= sda_d;
    if (!reset_n) arm_q <= 1'b0;
    else arm_q <= arm_d;
  end
  assign scl_s = scl_q[1];
  assign scl_p = scl_q[2];
  assign sda_s = sda_q[1];
  assign sda_p = sda_q[2];
  assign scl_rise = arm_q & scl_s & ~scl_p;
  assign scl_fall = arm_q & ~scl_s & scl_p;
  assign start_det = arm_q & scl_s & scl_p & sda_p & ~sda_s;
  assign stop_det = arm_q & scl_s & scl_p & ~sda_p & sda_s;
endmodule

// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: I2C target fronting a byte register file with an auto-incrementing pointer
module i2c_target_regfile
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEFAULT_DEV_ADDR,
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          scl_in,
  input  logic          sda_in,
  output logic          sda_oe,
  output logic          busy,
  output logic          wr_strobe,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  input  logic [AW-1:0] host_raddr,
  output logic [7:0]    host_rdata
);
  i2c_tgt_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d, byte_in, rd_byte, wr_data_q, wr_data_d;
  logic [AW-1:0] ptr_q, ptr_d, wr_addr_q, wr_addr_d;
  logic sda_oe_q, sda_oe_d, busy_q, busy_d, wr_strobe_q, wr_strobe_d;
  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];
  logic scl_rise, scl_fall, start_det, stop_det, sda_s, rx;

  i2c_bus_sync u_sync (
    .clk(clk), .reset_n(reset_n), .scl_in(scl_in), .sda_in(sda_in),
    .scl_rise(scl_rise), .scl_fall(scl_fall), .start_det(start_det),
    .stop_det(stop_det), .sda_s(sda_s)
  );

  assign byte_in = {sh_q[6:0], sda_s};
  assign rd_byte = mem_q[ptr_q];
  assign rx = state_q inside {ADDR, PTR, WDATA};

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    ptr_d = ptr_q;
    sda_oe_d = sda_oe_q;
    busy_d = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    mem_d = mem_q;
    if (stop_det) begin
      state_d = IDLE;
      sda_oe_d = 1'b0;
      busy_d = 1'b0;
    end else if (start_det) begin
      state_d = ADDR;
      cnt_d = '0;
      sda_oe_d = 1'b0;
      busy_d = 1'b0;
    end else if (scl_rise) begin
      if (state_q == RACK) begin
        if (sda_s == NACK) begin
          state_d = IGNORE;
          busy_d = 1'b0;
        end else begin
          cnt_d = 4'd1;
          ptr_d = ptr_q + 1'b1;
        end
      end else if (rx || state_q == RDATA) cnt_d = cnt_q + 4'd1;
      if (rx) sh_d = byte_in;
      if (rx && cnt_q == 4'd7 && state_q == PTR) ptr_d = byte_in[AW-1:0];
      if (rx && cnt_q == 4'd7 && state_q == WDATA) begin
        mem_d[ptr_q] = byte_in;
        wr_strobe_d = 1'b1;
        wr_addr_d = ptr_q;
        wr_data_d = byte_in;
        ptr_d = ptr_q + 1'b1;
      end
    end else if (scl_fall) begin
      if (rx && cnt_q == 4'd8) begin
        cnt_d = '0;
        if (state_q != ADDR) begin
          state_d = state_q == PTR ? PTR_ACK : WDATA_ACK;
          sda_oe_d = ~ACK;
        end else if (sh_q[7:1] == DEV_ADDR) begin
          state_d = ADDR_ACK;
          sda_oe_d = ~ACK;
          busy_d = 1'b1;
        end else state_d = IGNORE;
      end else if (state_q inside {ADDR_ACK, PTR_ACK, WDATA_ACK}) begin
        sda_oe_d = 1'b0;
        state_d = state_q == ADDR_ACK ? (sh_q[0] ? RDATA : PTR) : WDATA;
        if (state_q == ADDR_ACK && sh_q[0]) begin
          sh_d = rd_byte;
          sda_oe_d = ~rd_byte[7];
        end
      end else if (state_q == RDATA) begin
        if (cnt_q == 4'd8) begin
          state_d = RACK;
          cnt_d = '0;
          sda_oe_d = 1'b0;
        end else begin
          sh_d = {sh_q[6:0], 1'b0};
          sda_oe_d = ~sh_q[6];
        end
      end else if (state_q == RACK && cnt_q == 4'd1) begin
        state_d = RDATA;
        cnt_d = '0;
        sh_d = rd_byte;
        sda_oe_d = ~rd_byte[7];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sh_q <= '0;
      ptr_q <= '0;
      sda_oe_q <= 1'b0;
      busy_q <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      ptr_q <= ptr_d;
      sda_oe_q <= sda_oe_d;
      busy_q <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      mem_q <= mem_d;
    end
  end

  assign sda_oe = sda_oe_q;
  assign busy = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign host_rdata = mem_q[host_raddr];
endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb_i2c_target_regfile: randomized I2C master checked against a register-file model via scoreboard
module tb_i2c_target_regfile;
  import i2c_target_pkg::*;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam logic [6:0] DEV = 7'h50;
  logic clk = 1'b0, reset_n = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
  logic sda_oe, busy, wr_strobe, sda_line;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] host_raddr = '0;
  logic [7:0] wr_data, host_rdata;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] mem_m [DEPTH];
  int ptr_m = 0;
  int exp_wr[$];
  logic [7:0] exp_rd[$], act_rd[$];

  assign sda_line = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  i2c_target_regfile dut (
    .clk(clk), .reset_n(reset_n), .scl_in(scl_m), .sda_in(sda_line),
    .sda_oe(sda_oe), .busy(busy), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .wr_data(wr_data), .host_raddr(host_raddr), .host_rdata(host_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_strobe) begin
      if (exp_wr.size() == 0) chk("wr_unexpected", {20'd0, wr_addr, wr_data}, 32'hFFFF_FFFF);
      else chk("wr_strobe", {20'd0, wr_addr, wr_data}, exp_wr.pop_front());
    end
    while (act_rd.size() != 0 && exp_rd.size() != 0)
      chk("rd_byte", {24'd0, act_rd.pop_front()}, {24'd0, exp_rd.pop_front()});
  end

  task automatic wr_bit(input logic b);
    #20 sda_m = b;
    #60 scl_m = 1'b1;
    #80 scl_m = 1'b0;
  endtask

  task automatic rd_bit(output logic b);
    #20 sda_m = 1'b1;
    #60 scl_m = 1'b1;
    #40 b = sda_line;
    #40 scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic exp_ack, input string name);
    logic a;
    for (int i = 7; i >= 0; i--) wr_bit(d[i]);
    rd_bit(a);
    chk(name, {31'd0, a}, {31'd0, exp_ack});
  endtask

  task automatic recv_byte(input logic nack);
    logic [7:0] d;
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rd_bit(b);
      d[i] = b;
    end
    act_rd.push_back(d);
    wr_bit(nack);
  endtask

  task automatic start_c();
    sda_m = 1'b1;
    #80;
    if (!scl_m) begin
      scl_m = 1'b1;
      #80;
    end
    sda_m = 1'b0;
    #80 scl_m = 1'b0;
  endtask

  task automatic stop_c();
    sda_m = 1'b0;
    #80 scl_m = 1'b1;
    #80 sda_m = 1'b1;
    #160;
  endtask

  task automatic set_ptr(input logic [7:0] p);
    start_c();
    send_byte({DEV, 1'b0}, ACK, "addr_w_ack");
    chk("busy_after_addr", {31'd0, busy}, 32'd1);
    send_byte(p, ACK, "ptr_ack");
    ptr_m = int'(p) % DEPTH;
  endtask

  task automatic wr_byte(input logic [7:0] d);
    exp_wr.push_back(ptr_m * 256 + int'(d));
    mem_m[ptr_m] = d;
    ptr_m = (ptr_m + 1) % DEPTH;
    send_byte(d, ACK, "wdata_ack");
  endtask

  task automatic rd_seq(input int n);
    start_c();
    send_byte({DEV, 1'b1}, ACK, "addr_r_ack");
    for (int i = 0; i < n; i++) begin
      exp_rd.push_back(mem_m[ptr_m]);
      recv_byte(i == n - 1);
      if (i != n - 1) ptr_m = (ptr_m + 1) % DEPTH;
    end
    #60;
    chk("sda_released_nack", {31'd0, sda_oe}, 32'd0);
    chk("busy_after_nack", {31'd0, busy}, 32'd0);
  endtask

  task automatic bad_addr();
    logic [6:0] a;
    do a = 7'($urandom); while (a == DEV);
    start_c();
    send_byte({a, 1'($urandom)}, NACK, "nomatch_nack");
    chk("busy_nomatch", {31'd0, busy}, 32'd0);
  endtask

  task automatic abort_bits(input int k);
    for (int i = 0; i < k; i++) wr_bit(1'($urandom));
    stop_c();
  endtask

  task automatic sweep(input string name);
    for (int a = 0; a < DEPTH; a++) begin
      host_raddr = a[AW-1:0];
      #1 chk(name, {24'd0, host_rdata}, {24'd0, mem_m[a]});
    end
  endtask

  task automatic rand_xact();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 3) begin
      set_ptr(8'($urandom));
      repeat ($urandom_range(1, 4)) wr_byte(8'($urandom));
      stop_c();
    end else if (r <= 6) begin
      set_ptr(8'($urandom));
      rd_seq($urandom_range(1, 4));
      stop_c();
    end else if (r == 7) begin
      rd_seq($urandom_range(1, 4));
      stop_c();
    end else if (r == 8) begin
      bad_addr();
      set_ptr(8'($urandom));
      wr_byte(8'($urandom));
      stop_c();
    end else if ($urandom_range(0, 1) == 0) begin
      set_ptr(8'($urandom));
      abort_bits($urandom_range(1, 6));
    end else begin
      start_c();
      send_byte({DEV, 1'b0}, ACK, "addr_w_ack");
      abort_bits($urandom_range(1, 6));
    end
  endtask

  initial begin
    logic b;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
    chk("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    chk("rst_host_rdata", {24'd0, host_rdata}, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(negedge clk);
    set_ptr(8'h03);
    wr_byte(8'h5A);
    wr_byte(8'hC3);
    stop_c();
    host_raddr = 4'd3;
    #1 chk("host_rdata_3", {24'd0, host_rdata}, 32'h5A);
    host_raddr = 4'd4;
    #1 chk("host_rdata_4", {24'd0, host_rdata}, 32'hC3);
    rd_seq(1);
    stop_c();
    set_ptr(8'h03);
    rd_seq(2);
    stop_c();
    bad_addr();
    set_ptr(8'h08);
    stop_c();
    set_ptr(8'h0F);
    wr_byte(8'h11);
    wr_byte(8'h22);
    stop_c();
    host_raddr = 4'd15;
    #1 chk("wrap_mem15", {24'd0, host_rdata}, 32'h11);
    host_raddr = 4'd0;
    #1 chk("wrap_mem0", {24'd0, host_rdata}, 32'h22);
    rd_seq(1);
    stop_c();
    set_ptr(8'h07);
    abort_bits(5);
    rd_seq(1);
    stop_c();
    for (int it = 0; it < 30; it++) rand_xact();
    sweep("mem_after_random");
    set_ptr(8'h02);
    wr_byte(8'h00);
    set_ptr(8'h02);
    start_c();
    send_byte({DEV, 1'b1}, ACK, "addr_r_ack");
    repeat (3) rd_bit(b);
    #60 chk("drive_bit4_low", {31'd0, sda_oe}, 32'd1);
    @(negedge clk) reset_n = 1'b0;
    @(posedge clk) #1 chk("reset_releases_sda", {31'd0, sda_oe}, 32'd0);
    repeat (4) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
    ptr_m = 0;
    sweep("mem_after_reset");
    rd_seq(1);
    stop_c();
    for (int it = 0; it < 8; it++) rand_xact();
    sweep("mem_final");
    repeat (20) @(posedge clk);
    chk("wr_queue_drained", exp_wr.size(), 32'd0);
    chk("rd_queue_drained", exp_rd.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
